// File: rtl/lc3_regfile_cc_pkg.sv
// Shared types and constants for the LC-3 register file and condition-code logic.
// The optional macro REGFILE_BYPASS_EN is not used here; see lc3_regfile_cc.sv.
package lc3_pkg;

  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int AW    = $clog2(NREGS);

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [AW-1:0]    reg_addr_t;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } nzp_t;

  localparam reg_addr_t R7_ADDR   = 3'b111;
  localparam nzp_t      NZP_RESET = 3'b000;

  // Exactly one of N/Z/P is set for any word.
  function automatic nzp_t cc_from_word(input word_t w);
    nzp_t cc;
    cc.n = w[WIDTH-1];
    cc.z = (w == {WIDTH{1'b0}});
    cc.p = ~cc.n & ~cc.z;
    return cc;
  endfunction

endpackage

// File: rtl/lc3_regfile_cc_if.sv
// Bus bundle between the datapath/control and the register file + CC block.
// master drives loads, addresses and bus; slave returns operands and NZP/BEN.
interface lc3_regfile_cc_if
  import lc3_pkg::*;
  ();

  logic      ld_reg;
  reg_addr_t dr_addr;
  reg_addr_t sr1_addr;
  reg_addr_t sr2_addr;
  word_t     bus;
  logic      ld_cc;
  logic      ld_ben;
  logic [2:0] ir_nzp;
  word_t     sr1_out;
  word_t     sr2_out;
  nzp_t      nzp;
  logic      ben;

  modport master (
    output ld_reg, dr_addr, sr1_addr, sr2_addr, bus, ld_cc, ld_ben, ir_nzp,
    input  sr1_out, sr2_out, nzp, ben
  );

  modport slave (
    input  ld_reg, dr_addr, sr1_addr, sr2_addr, bus, ld_cc, ld_ben, ir_nzp,
    output sr1_out, sr2_out, nzp, ben
  );

endinterface

// File: rtl/lc3_cc_unit.sv
// Condition-code (NZP) and branch-enable registers fed from the internal bus.
// BEN is evaluated against the NZP value held before the current edge.
module lc3_cc_unit
  import lc3_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ld_cc,
  input  logic       ld_ben,
  input  word_t      bus,
  input  logic [2:0] ir_nzp,
  output nzp_t       nzp,
  output logic       ben
);

  nzp_t nzp_r;
  logic ben_r;
  nzp_t cc_s;

  assign cc_s = cc_from_word(bus);

  // NZP and BEN state; reset wins over both loads.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      nzp_r <= NZP_RESET;
      ben_r <= 1'b0;
    end else begin
      if (ld_cc) begin
        nzp_r <= cc_s;
      end
      if (ld_ben) begin
        ben_r <= |(ir_nzp & nzp_r);
      end
    end
  end

  assign nzp = nzp_r;
  assign ben = ben_r;

endmodule

// File: rtl/lc3_regfile_cc.sv
// LC-3 R0-R7 register file with two read ports, plus the NZP/BEN unit.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to matching read ports.
module lc3_regfile_cc
  import lc3_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  lc3_regfile_cc_if.slave    rf
);

  word_t            gpr_r [NREGS];
  logic [NREGS-1:0] wr_en_s;
  word_t            sr1_s;
  word_t            sr2_s;
  nzp_t             nzp_s;
  logic             ben_s;

  // One-hot write decode of the destination address.
  always_comb begin
    wr_en_s = {NREGS{1'b0}};
    if (rf.ld_reg) begin
      wr_en_s[rf.dr_addr] = 1'b1;
    end else begin
      wr_en_s = {NREGS{1'b0}};
    end
  end

  // GPR array; a write in the reset cycle is discarded.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) begin
        gpr_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en_s[i]) begin
          gpr_r[i] <= rf.bus;
        end
      end
    end
  end

  // Read ports, each forwarding independently when bypass is built in.
  always_comb begin
    sr1_s = gpr_r[rf.sr1_addr];
    sr2_s = gpr_r[rf.sr2_addr];
`ifdef REGFILE_BYPASS_EN
    if (rf.ld_reg && (rf.sr1_addr == rf.dr_addr)) begin
      sr1_s = rf.bus;
    end else begin
      sr1_s = gpr_r[rf.sr1_addr];
    end
    if (rf.ld_reg && (rf.sr2_addr == rf.dr_addr)) begin
      sr2_s = rf.bus;
    end else begin
      sr2_s = gpr_r[rf.sr2_addr];
    end
`else
    sr1_s = gpr_r[rf.sr1_addr];
    sr2_s = gpr_r[rf.sr2_addr];
`endif
  end

  assign rf.sr1_out = sr1_s;
  assign rf.sr2_out = sr2_s;

  lc3_cc_unit u_cc (
    .Clk    (Clk),
    .Reset  (Reset),
    .ld_cc  (rf.ld_cc),
    .ld_ben (rf.ld_ben),
    .bus    (rf.bus),
    .ir_nzp (rf.ir_nzp),
    .nzp    (nzp_s),
    .ben    (ben_s)
  );

  assign rf.nzp = nzp_s;
  assign rf.ben = ben_s;

endmodule

// File: tb/tb_lc3_regfile_cc.sv
// Self-checking bench for lc3_regfile_cc: directed cases then random traffic
// against an array-based reference model.
module tb_lc3_regfile_cc;
  import lc3_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  lc3_regfile_cc_if rf ();

  lc3_regfile_cc dut (
    .Clk   (Clk),
    .Reset (Reset),
    .rf    (rf)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] m_regs [8];
  logic [2:0]  m_nzp;
  logic        m_ben;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
    if (rf.ld_reg === 1'b1 && a == rf.dr_addr) return rf.bus;
`endif
    return m_regs[a];
  endfunction

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if (v == 16'h0000) return 3'b010;
    if (v >= 16'h8000) return 3'b100;
    return 3'b001;
  endfunction

  // Apply inputs, then settle 1 time unit so combinational reads can be inspected.
  task automatic drive(input logic rst, input logic ldr, input logic [2:0] dr,
                       input logic [15:0] b, input logic ldc, input logic ldb,
                       input logic [2:0] ir, input logic [2:0] s1, input logic [2:0] s2);
    Reset       = rst;
    rf.ld_reg   = ldr;
    rf.dr_addr  = dr;
    rf.bus      = b;
    rf.ld_cc    = ldc;
    rf.ld_ben   = ldb;
    rf.ir_nzp   = ir;
    rf.sr1_addr = s1;
    rf.sr2_addr = s2;
    #1;
  endtask

  task automatic idle(input logic [2:0] s1, input logic [2:0] s2);
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b000, s1, s2);
  endtask

  // Check read ports, clock once, update the model, check NZP/BEN.
  task automatic tick(input string tag);
    logic [2:0] old_nzp;
    check({tag, "/sr1"}, rf.sr1_out, exp_read(rf.sr1_addr));
    check({tag, "/sr2"}, rf.sr2_out, exp_read(rf.sr2_addr));
    @(posedge Clk);
    if (Reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_nzp = 3'b000;
      m_ben = 1'b0;
    end else begin
      old_nzp = m_nzp;
      if (rf.ld_reg) m_regs[rf.dr_addr] = rf.bus;
      if (rf.ld_cc)  m_nzp = cc_of(rf.bus);
      if (rf.ld_ben) m_ben = ((rf.ir_nzp & old_nzp) != 3'b000);
    end
    #1;
    check({tag, "/nzp"}, {13'd0, rf.nzp}, {13'd0, m_nzp});
    check({tag, "/ben"}, {15'd0, rf.ben}, {15'd0, m_ben});
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_nzp = 3'b000;
    m_ben = 1'b0;

    // Power-up reset (contents undefined before it, so no read checks here)
    @(negedge Clk);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b000, 3'd0, 3'd0);
    @(posedge Clk);
    #1;

    // Reset with every load asserted
    drive(1'b1, 1'b1, 3'd4, 16'hFFFF, 1'b1, 1'b1, 3'b111, 3'd0, 3'd1);
    tick("rst_all_loads");
    check("rst_nzp", {13'd0, rf.nzp}, 16'h0000);
    check("rst_ben", {15'd0, rf.ben}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      idle(i[2:0], 3'(7 - i));
      check("rst_gpr", rf.sr1_out, 16'h0000);
      tick("rst_read");
    end

    // Linkage write to R7
    drive(1'b0, 1'b1, R7_ADDR, 16'h1234, 1'b0, 1'b0, 3'b000, 3'd0, 3'd0);
    tick("r7_write");
    idle(3'd7, 3'd7);
    check("r7_sr1", rf.sr1_out, 16'h1234);
    check("r7_sr2", rf.sr2_out, 16'h1234);
    tick("r7_read");
    for (int i = 0; i < 7; i++) begin
      idle(i[2:0], i[2:0]);
      check("r0_r6_untouched", rf.sr1_out, 16'h0000);
      tick("r0_r6_read");
    end

    // Condition codes from boundary bus values
    drive(1'b0, 1'b0, 3'd0, 16'h8000, 1'b1, 1'b0, 3'b000, 3'd0, 3'd0);
    tick("cc_8000");
    check("cc_n", {13'd0, rf.nzp}, 16'h0004);
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'b000, 3'd0, 3'd0);
    tick("cc_0000");
    check("cc_z", {13'd0, rf.nzp}, 16'h0002);
    drive(1'b0, 1'b0, 3'd0, 16'h0001, 1'b1, 1'b0, 3'b000, 3'd0, 3'd0);
    tick("cc_0001");
    check("cc_p", {13'd0, rf.nzp}, 16'h0001);

    // BEN sees the old CC when loaded alongside a new one
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'b001, 3'd0, 3'd0);
    tick("ben_old_cc");
    check("ben_old_cc_ben", {15'd0, rf.ben}, 16'h0001);
    check("ben_old_cc_nzp", {13'd0, rf.nzp}, 16'h0002);
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'b001, 3'd0, 3'd0);
    tick("ben_reeval");
    check("ben_reeval_ben", {15'd0, rf.ben}, 16'h0000);

    drive(1'b0, 1'b0, 3'd0, 16'h7FFF, 1'b1, 1'b0, 3'b000, 3'd0, 3'd0);
    tick("cc_7fff");
    check("cc_7fff_p", {13'd0, rf.nzp}, 16'h0001);

    // Same-cycle write and read of R3
    drive(1'b0, 1'b1, 3'd3, 16'h5555, 1'b0, 1'b0, 3'b000, 3'd0, 3'd0);
    tick("r3_pre");
    drive(1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b0, 3'b000, 3'd3, 3'd0);
`ifdef REGFILE_BYPASS_EN
    check("r3_same_cycle", rf.sr1_out, 16'hBEEF);
`else
    check("r3_same_cycle", rf.sr1_out, 16'h5555);
`endif
    tick("r3_write");
    idle(3'd3, 3'd3);
    check("r3_next_cycle", rf.sr1_out, 16'hBEEF);
    tick("r3_read");

    // Fill all registers, then reset with a write pending
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      drive(1'b0, 1'b1, i[2:0], d[15:0] | 16'h0100, 1'b1, 1'b0, 3'b000, i[2:0], 3'd0);
      tick("fill");
    end
    drive(1'b1, 1'b1, 3'd2, 16'hAAAA, 1'b1, 1'b1, 3'b111, 3'd2, 3'd5);
    tick("mid_reset");
    for (int i = 0; i < 8; i++) begin
      idle(i[2:0], i[2:0]);
      check("mid_reset_gpr", rf.sr2_out, 16'h0000);
      tick("mid_reset_read");
    end

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      r = $urandom;
      d = $urandom;
      case (r[27:26])
        2'd0:    d[15:0] = 16'h0000;
        2'd1:    d[15:0] = {1'b1, d[14:0]};
        default: d[15:0] = d[15:0];
      endcase
      drive((r[31:26] == 6'd0), r[0], r[3:1], d[15:0], r[4], r[5], r[8:6], r[11:9], r[14:12]);
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
